mem_dma: RTL and testbench

//  Block-move initiator on the QX1 single-port memory interface (clk, addr, write data,

---
 rtl/qx1_pkg.sv | 15 +
 rtl/dma_addr_gen.sv | 45 ++++
 rtl/mem_dma.sv | 190 +++++++++++++++++++
 tb/tb_mem_dma.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qx1_pkg.sv
// Shared QX1 definitions: DMA controller state encoding and transfer mode values.
package qx1_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        FIN   = 3'd4
    } dma_state_t;

    localparam logic DMA_MODE_COPY = 1'b0;
    localparam logic DMA_MODE_FILL = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable address pointer with +1/-1 stepping; arithmetic wraps naturally modulo 2**ADDR_W.
module dma_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_step,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_addr_nxt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;

    // Next pointer value: load wins over step; the next value is exported so the
    // parent can register bus outputs in step with the pointer.
    always_comb begin
        w_addr_nxt = r_addr;
        if (i_load) begin
            w_addr_nxt = i_load_val;
        end else if (i_step) begin
            w_addr_nxt = i_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
        end else begin
            w_addr_nxt = r_addr;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= {ADDR_W{1'b0}};
        end else begin
            r_addr <= w_addr_nxt;
        end
    end

    assign o_addr     = r_addr;
    assign o_addr_nxt = w_addr_nxt;

endmodule

// File: rtl/mem_dma.sv
// Block copy/fill initiator on a single-port memory with combinational read data.
// Overlapping copies run descending so the source is never clobbered before it is read.
module mem_dma
    import qx1_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic              r_mode;
    logic              r_down;
    logic [LEN_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_fill;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_load;
    logic              w_step;
    logic              w_abort_end;
    logic              w_overlap;
    logic [ADDR_W-1:0] w_src_val;
    logic [ADDR_W-1:0] w_dst_val;
    logic [ADDR_W-1:0] w_src_addr;
    logic [ADDR_W-1:0] w_dst_addr;
    logic [ADDR_W-1:0] w_src_nxt;
    logic [ADDR_W-1:0] w_dst_nxt;
    logic [ADDR_W-1:0] w_diff;
    logic [ADDR_W-1:0] w_len_m1;

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_src_val),
        .i_step     (w_step),
        .i_down     (r_down),
        .o_addr     (w_src_addr),
        .o_addr_nxt (w_src_nxt)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_dst_val),
        .i_step     (w_step),
        .i_down     (r_down),
        .o_addr     (w_dst_addr),
        .o_addr_nxt (w_dst_nxt)
    );

    // Overlap test uses the pointers loaded at start and the latched length.
    assign w_diff    = w_dst_addr - w_src_addr;
    assign w_len_m1  = ADDR_W'(r_rem - LEN_ONE);
    assign w_overlap = (r_mode == DMA_MODE_COPY) && (w_diff != {ADDR_W{1'b0}}) &&
                       (CMP_W'(w_diff) < CMP_W'(r_rem));

    // Next-state, pointer load/step and abort bookkeeping
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_abort_end = 1'b0;
        w_src_val   = src_addr;
        w_dst_val   = dst_addr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SETUP;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            SETUP: begin
                if (abort) begin
                    w_next      = FIN;
                    w_abort_end = 1'b1;
                end else if (r_rem == LEN_ZERO) begin
                    w_next = FIN;
                end else begin
                    w_next    = (r_mode == DMA_MODE_FILL) ? WR : RD;
                    w_load    = w_overlap;
                    w_src_val = w_src_addr + w_len_m1;
                    w_dst_val = w_dst_addr + w_len_m1;
                end
            end
            RD: begin
                if (abort) begin
                    w_next      = FIN;
                    w_abort_end = 1'b1;
                end else begin
                    w_next = WR;
                end
            end
            WR: begin
                w_step = 1'b1;
                if (abort) begin
                    w_next      = FIN;
                    w_abort_end = 1'b1;
                end else if (r_rem == LEN_ONE) begin
                    w_next = FIN;
                end else begin
                    w_next = (r_mode == DMA_MODE_FILL) ? WR : RD;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, transfer latches and registered bus/status outputs keyed off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= DMA_MODE_COPY;
            r_down    <= 1'b0;
            r_rem     <= LEN_ZERO;
            r_fill    <= {DATA_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
        end else begin
            r_state   <= w_next;
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == FIN);
            r_aborted <= (w_next == FIN) && w_abort_end;
            r_we      <= (w_next == WR);
            if (r_state == IDLE && start) begin
                r_mode <= mode;
                r_rem  <= len;
                r_fill <= fill_data;
            end else if (w_step) begin
                r_rem <= r_rem - LEN_ONE;
            end
            if (r_state == SETUP) begin
                r_down <= w_overlap;
            end
            if (w_next == RD) begin
                r_addr <= w_src_nxt;
            end else if (w_next == WR) begin
                r_addr  <= w_dst_nxt;
                r_wdata <= (r_mode == DMA_MODE_FILL) ? r_fill : mem_read_data;
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign aborted         = r_aborted;
    assign mem_access_addr = r_addr;
    assign mem_write_data  = r_wdata;
    assign mem_write_en    = r_we;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma paired with a simple single-port memory responder.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic [15:0] fill_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] mem_read_data;

    logic [15:0] mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_addr;
    logic [15:0] tb_data;

    int          checks   = 0;
    int          failures = 0;
    int          x_cycles;
    int          x_writes;
    logic [15:0] x_first_wa;
    logic        x_aborted;

    always #5 clk = ~clk;

    mem_dma dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mode            (mode),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len             (len),
        .fill_data       (fill_data),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read_data   (mem_read_data)
    );

    assign mem_read_data = mem[mem_access_addr];

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge clk);
        #1;
        tb_we   = 1'b0;
    endtask

    // Launch one transfer; cycle index 0 is the start cycle. abort_at=N raises abort in the Nth WR cycle.
    task automatic run_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input logic [15:0] f, input int abort_at);
        mode       = m;
        src_addr   = s;
        dst_addr   = d;
        len        = n;
        fill_data  = f;
        start      = 1'b1;
        x_writes   = 0;
        x_first_wa = 16'h0000;
        @(posedge clk);
        #1;
        start    = 1'b0;
        x_cycles = 1;
        while (done !== 1'b1 && x_cycles < 300) begin
            if (mem_write_en === 1'b1) begin
                if (x_writes == 0) x_first_wa = mem_access_addr;
                x_writes++;
                abort = (abort_at != 0) && (x_writes == abort_at);
            end else begin
                abort = 1'b0;
            end
            @(posedge clk);
            #1;
            x_cycles++;
        end
        abort = 1'b0;
        if (done !== 1'b1) chk("done_within_budget", 32'd0, 32'd1);
        x_aborted = aborted;
    endtask

    initial begin
        int ndone;
        int nwr;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        src_addr  = 16'h0000;
        dst_addr  = 16'h0000;
        len       = 16'h0000;
        fill_data = 16'h0000;
        abort     = 1'b0;
        tb_we     = 1'b0;
        tb_addr   = 16'h0000;
        tb_data   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_we", {31'd0, mem_write_en}, 32'd0);
        chk("rst_addr", {16'd0, mem_access_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_write_data}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain ascending copy
        for (int i = 0; i < 4; i++) begin
            poke(16'(16'h0100 + i), 16'(16'hA0A0 + i));
            poke(16'(16'h0200 + i), 16'h0000);
        end
        run_xfer(1'b0, 16'h0100, 16'h0200, 16'd4, 16'h0000, 0);
        chk("copy_done_cycle", x_cycles, 32'd10);
        chk("copy_writes", x_writes, 32'd4);
        chk("copy_first_wa", {16'd0, x_first_wa}, 32'h0200);
        chk("copy_aborted", {31'd0, x_aborted}, 32'd0);
        chk("copy_busy_in_fin", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("copy_busy_after", {31'd0, busy}, 32'd0);
        chk("copy_done_after", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("copy_dst", {16'd0, mem[16'h0200 + i]}, {16'd0, 16'(16'hA0A0 + i)});
            chk("copy_src", {16'd0, mem[16'h0100 + i]}, {16'd0, 16'(16'hA0A0 + i)});
        end

        // Overlapping copy forward by two words
        for (int i = 0; i < 6; i++) poke(16'(16'h0010 + i), (i < 4) ? 16'(i + 1) : 16'h0000);
        run_xfer(1'b0, 16'h0010, 16'h0012, 16'd4, 16'h0000, 0);
        chk("ovl_done_cycle", x_cycles, 32'd10);
        chk("ovl_first_wa", {16'd0, x_first_wa}, 32'h0015);
        for (int i = 0; i < 4; i++)
            chk("ovl_dst", {16'd0, mem[16'h0012 + i]}, 32'(i + 1));
        chk("ovl_keep0", {16'd0, mem[16'h0010]}, 32'd1);
        chk("ovl_keep1", {16'd0, mem[16'h0011]}, 32'd2);

        // Fill across the top of the address space
        poke(16'hFFFD, 16'h1111);
        poke(16'h0002, 16'h2222);
        run_xfer(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'hBEEF, 0);
        chk("fill_done_cycle", x_cycles, 32'd6);
        chk("fill_writes", x_writes, 32'd4);
        chk("fill_first_wa", {16'd0, x_first_wa}, 32'hFFFE);
        chk("fill_fffe", {16'd0, mem[16'hFFFE]}, 32'hBEEF);
        chk("fill_ffff", {16'd0, mem[16'hFFFF]}, 32'hBEEF);
        chk("fill_0000", {16'd0, mem[16'h0000]}, 32'hBEEF);
        chk("fill_0001", {16'd0, mem[16'h0001]}, 32'hBEEF);
        chk("fill_below", {16'd0, mem[16'hFFFD]}, 32'h1111);
        chk("fill_above", {16'd0, mem[16'h0002]}, 32'h2222);
        @(posedge clk);
        #1;

        // Empty transfer
        run_xfer(1'b0, 16'h0100, 16'h0300, 16'd0, 16'h0000, 0);
        chk("len0_done_cycle", x_cycles, 32'd2);
        chk("len0_writes", x_writes, 32'd0);
        chk("len0_aborted", {31'd0, x_aborted}, 32'd0);
        @(posedge clk);
        #1;

        // Abort during the third write
        for (int i = 0; i < 8; i++) begin
            poke(16'(16'h0300 + i), 16'(16'h3000 + i));
            poke(16'(16'h0400 + i), 16'h0000);
        end
        run_xfer(1'b0, 16'h0300, 16'h0400, 16'd8, 16'h0000, 3);
        chk("abort_done_cycle", x_cycles, 32'd8);
        chk("abort_writes", x_writes, 32'd3);
        chk("abort_flag", {31'd0, x_aborted}, 32'd1);
        for (int i = 0; i < 3; i++)
            chk("abort_dst", {16'd0, mem[16'h0400 + i]}, {16'd0, 16'(16'h3000 + i)});
        chk("abort_unwritten", {16'd0, mem[16'h0403]}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_flag_clears", {31'd0, aborted}, 32'd0);

        // start while busy and during FIN must be ignored
        poke(16'h0700, 16'h7700);
        poke(16'h0701, 16'h7701);
        poke(16'h0900, 16'h9999);
        mode      = 1'b0;
        src_addr  = 16'h0700;
        dst_addr  = 16'h0800;
        len       = 16'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        mode      = 1'b1;
        dst_addr  = 16'h0900;
        len       = 16'd5;
        fill_data = 16'hDEAD;
        start     = 1'b0;
        ndone     = 0;
        nwr       = 0;
        for (int k = 1; k < 20; k++) begin
            if (done === 1'b1) ndone++;
            if (mem_write_en === 1'b1) nwr++;
            start = (k == 3) || (done === 1'b1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("restart_done_count", ndone, 32'd1);
        chk("restart_writes", nwr, 32'd2);
        chk("restart_dst0", {16'd0, mem[16'h0800]}, 32'h7700);
        chk("restart_dst1", {16'd0, mem[16'h0801]}, 32'h7701);
        chk("restart_no_fill", {16'd0, mem[16'h0900]}, 32'h9999);
        chk("restart_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a write cycle
        poke(16'h0500, 16'h1234);
        poke(16'h0600, 16'h5555);
        mode     = 1'b0;
        src_addr = 16'h0500;
        dst_addr = 16'h0600;
        len      = 16'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nwr   = 0;
        while (mem_write_en !== 1'b1 && nwr < 20) begin
            @(posedge clk);
            #1;
            nwr++;
        end
        chk("rstmid_reached_wr", {31'd0, mem_write_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_we", {31'd0, mem_write_en}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_no_write", {16'd0, mem[16'h0600]}, 32'h5555);
        chk("rstmid_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
